// File: rtl/sel_ajuste_campos.sv
// Field cursor and per-field value editor for the clock/date/chronometer adjust path.
// Buttons are edge-detected here; every output is registered and updated on the edge that samples the action.
module sel_ajuste_campos #(
  parameter int                                NUM_CAMPOS  = 3,
  parameter int                                ANCHO_CAMPO = 2,
  parameter int                                ANCHO_VAL   = 6,
  parameter logic [NUM_CAMPOS*ANCHO_VAL-1:0]   MAX_VALS    = {6'd59, 6'd59, 6'd23},
  parameter bit                                WRAP_CURSOR = 1'b1
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic                                 en_ajuste,
  input  logic                                 btn_der,
  input  logic                                 btn_izq,
  input  logic                                 btn_arriba,
  input  logic                                 btn_abajo,
  input  logic                                 cargar,
  input  logic [NUM_CAMPOS*ANCHO_VAL-1:0]      dato_carga,
  output logic [ANCHO_CAMPO-1:0]               campo_sel,
  output logic [NUM_CAMPOS-1:0]                en_campo,
  output logic [NUM_CAMPOS*ANCHO_VAL-1:0]      valores,
  output logic                                 cambio
);

  localparam logic [ANCHO_CAMPO-1:0] ULTIMO = ANCHO_CAMPO'(NUM_CAMPOS - 1);

  logic [3:0]                        niveles;
  logic [3:0]                        prev;
  logic [3:0]                        pulsos;
  logic                              p_der, p_izq, p_arr, p_aba;

  logic [ANCHO_CAMPO-1:0]            cursor_sig;
  logic [NUM_CAMPOS-1:0]             en_sig;
  logic [NUM_CAMPOS*ANCHO_VAL-1:0]   valores_sig;
  logic                              cambio_sig;
  logic [ANCHO_VAL-1:0]              campo_act;
  logic [ANCHO_VAL-1:0]              max_act;
  logic [ANCHO_VAL-1:0]              nuevo;
  logic [ANCHO_VAL-1:0]              dato_i;
  logic [ANCHO_VAL-1:0]              max_i;

  assign niveles = {btn_der, btn_izq, btn_arriba, btn_abajo};
  assign pulsos  = niveles & ~prev;
  assign p_der   = pulsos[3];
  assign p_izq   = pulsos[2];
  assign p_arr   = pulsos[1];
  assign p_aba   = pulsos[0];

  always_comb begin
    cursor_sig  = campo_sel;
    valores_sig = valores;
    cambio_sig  = 1'b0;
    campo_act   = '0;
    max_act     = '0;
    nuevo       = '0;
    dato_i      = '0;
    max_i       = '0;
    en_sig      = '0;

    // Value edits target the field selected before this cycle's cursor move.
    for (int unsigned i = 0; i < NUM_CAMPOS; i++) begin
      if (campo_sel == ANCHO_CAMPO'(i)) begin
        campo_act = valores[i*ANCHO_VAL +: ANCHO_VAL];
        max_act   = MAX_VALS[i*ANCHO_VAL +: ANCHO_VAL];
      end
    end

    if (cargar) begin
      for (int unsigned i = 0; i < NUM_CAMPOS; i++) begin
        dato_i = dato_carga[i*ANCHO_VAL +: ANCHO_VAL];
        max_i  = MAX_VALS[i*ANCHO_VAL +: ANCHO_VAL];
        valores_sig[i*ANCHO_VAL +: ANCHO_VAL] = (dato_i > max_i) ? max_i : dato_i;
      end
    end else if (en_ajuste) begin
      if (p_der && !p_izq) begin
        if (campo_sel == ULTIMO) cursor_sig = WRAP_CURSOR ? '0 : ULTIMO;
        else                     cursor_sig = campo_sel + ANCHO_CAMPO'(1);
      end else if (p_izq && !p_der) begin
        if (campo_sel == '0) cursor_sig = WRAP_CURSOR ? ULTIMO : '0;
        else                 cursor_sig = campo_sel - ANCHO_CAMPO'(1);
      end

      if (p_arr != p_aba) begin
        cambio_sig = 1'b1;
        if (p_arr) nuevo = (campo_act == max_act) ? '0 : campo_act + ANCHO_VAL'(1);
        else       nuevo = (campo_act == '0) ? max_act : campo_act - ANCHO_VAL'(1);
        for (int unsigned i = 0; i < NUM_CAMPOS; i++) begin
          if (campo_sel == ANCHO_CAMPO'(i)) valores_sig[i*ANCHO_VAL +: ANCHO_VAL] = nuevo;
        end
      end
    end

    if (en_ajuste) begin
      for (int unsigned i = 0; i < NUM_CAMPOS; i++) begin
        if (cursor_sig == ANCHO_CAMPO'(i)) en_sig[i] = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      prev      <= '0;
      campo_sel <= '0;
      en_campo  <= '0;
      valores   <= '0;
      cambio    <= 1'b0;
    end else begin
      prev      <= niveles;
      campo_sel <= cursor_sig;
      en_campo  <= en_sig;
      valores   <= valores_sig;
      cambio    <= cambio_sig;
    end
  end

endmodule

// File: tb/tb_sel_ajuste_campos.sv
// Scoreboard bench for sel_ajuste_campos: wrapping and saturating instances share all inputs.
module tb_sel_ajuste_campos;

  localparam int N = 3;
  localparam int W = 6;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic           rst = 1'b1;
  logic           en_ajuste = 1'b0;
  logic           btn_der = 1'b0, btn_izq = 1'b0, btn_arriba = 1'b0, btn_abajo = 1'b0;
  logic           cargar = 1'b0;
  logic [N*W-1:0] dato_carga = '0;

  logic [1:0]     sel_w, sel_s;
  logic [N-1:0]   enc_w, enc_s;
  logic [N*W-1:0] val_w, val_s;
  logic           cam_w, cam_s;

  sel_ajuste_campos #(.NUM_CAMPOS(N), .ANCHO_CAMPO(2), .ANCHO_VAL(W),
                      .MAX_VALS({6'd59, 6'd59, 6'd23}), .WRAP_CURSOR(1'b1)) u_wrap (
    .clk(clk), .rst(rst), .en_ajuste(en_ajuste),
    .btn_der(btn_der), .btn_izq(btn_izq), .btn_arriba(btn_arriba), .btn_abajo(btn_abajo),
    .cargar(cargar), .dato_carga(dato_carga),
    .campo_sel(sel_w), .en_campo(enc_w), .valores(val_w), .cambio(cam_w));

  sel_ajuste_campos #(.NUM_CAMPOS(N), .ANCHO_CAMPO(2), .ANCHO_VAL(W),
                      .MAX_VALS({6'd59, 6'd59, 6'd23}), .WRAP_CURSOR(1'b0)) u_sat (
    .clk(clk), .rst(rst), .en_ajuste(en_ajuste),
    .btn_der(btn_der), .btn_izq(btn_izq), .btn_arriba(btn_arriba), .btn_abajo(btn_abajo),
    .cargar(cargar), .dato_carga(dato_carga),
    .campo_sel(sel_s), .en_campo(enc_s), .valores(val_s), .cambio(cam_s));

  typedef struct packed {
    logic [1:0]     sel;
    logic [N-1:0]   enc;
    logic [N*W-1:0] val;
    logic           cam;
  } salida_t;

  typedef struct packed {
    salida_t w;
    salida_t s;
  } esperado_t;

  esperado_t cola[$];
  int n_vec = 0;
  int n_err = 0;

  // Reference state: index 0 = wrapping cursor, 1 = saturating cursor.
  int cur [2];
  int v   [2][N];
  bit prev[4];
  int maxv[N] = '{23, 59, 59};

  task automatic paso(input bit r, input bit e, input bit d, input bit i,
                      input bit u, input bit dn, input bit c, input logic [N*W-1:0] dato);
    bit pd, pi, pu, pdn;
    int cam;
    int dv;
    salida_t o[2];
    esperado_t ex;
    @(negedge clk);
    rst = r; en_ajuste = e; btn_der = d; btn_izq = i;
    btn_arriba = u; btn_abajo = dn; cargar = c; dato_carga = dato;

    pd = d && !prev[0]; pi = i && !prev[1]; pu = u && !prev[2]; pdn = dn && !prev[3];
    if (r) begin
      prev = '{0, 0, 0, 0};
    end else begin
      prev[0] = d; prev[1] = i; prev[2] = u; prev[3] = dn;
    end

    for (int k = 0; k < 2; k++) begin
      cam = 0;
      if (r) begin
        cur[k] = 0;
        for (int f = 0; f < N; f++) v[k][f] = 0;
      end else if (c) begin
        for (int f = 0; f < N; f++) begin
          dv = int'(dato[f*W +: W]);
          v[k][f] = (dv > maxv[f]) ? maxv[f] : dv;
        end
      end else if (e) begin
        int old;
        old = cur[k];
        if (pd && !pi)
          cur[k] = (k == 0) ? (cur[k] + 1) % N : ((cur[k] == N - 1) ? cur[k] : cur[k] + 1);
        if (pi && !pd)
          cur[k] = (k == 0) ? (cur[k] + N - 1) % N : ((cur[k] == 0) ? 0 : cur[k] - 1);
        if (pu != pdn) begin
          cam = 1;
          if (pu) v[k][old] = (v[k][old] == maxv[old]) ? 0 : v[k][old] + 1;
          else    v[k][old] = (v[k][old] == 0) ? maxv[old] : v[k][old] - 1;
        end
      end
      o[k].sel = 2'(cur[k]);
      o[k].enc = (e && !r) ? N'(1 << cur[k]) : '0;
      o[k].cam = (cam != 0);
      for (int f = 0; f < N; f++) o[k].val[f*W +: W] = W'(v[k][f]);
    end
    ex.w = o[0];
    ex.s = o[1];
    cola.push_back(ex);
  endtask

  task automatic chequear(input string nom, input salida_t x,
                          input logic [1:0] sel, input logic [N-1:0] enc,
                          input logic [N*W-1:0] val, input logic cam);
    n_vec += 4;
    if (sel !== x.sel) begin
      n_err++; $display("FAIL %s campo_sel: got %0d expected %0d at %0t", nom, sel, x.sel, $time);
    end
    if (enc !== x.enc) begin
      n_err++; $display("FAIL %s en_campo: got %b expected %b at %0t", nom, enc, x.enc, $time);
    end
    if (val !== x.val) begin
      n_err++; $display("FAIL %s valores: got %h expected %h at %0t", nom, val, x.val, $time);
    end
    if (cam !== x.cam) begin
      n_err++; $display("FAIL %s cambio: got %b expected %b at %0t", nom, cam, x.cam, $time);
    end
  endtask

  always @(posedge clk) begin
    esperado_t ex;
    #1;
    if (cola.size() > 0) begin
      ex = cola.pop_front();
      chequear("wrap", ex.w, sel_w, enc_w, val_w, cam_w);
      chequear("sat",  ex.s, sel_s, enc_s, val_s, cam_s);
    end
  end

  localparam logic [N*W-1:0] CERO = '0;

  initial begin
    for (int k = 0; k < 2; k++) begin
      cur[k] = 0;
      for (int f = 0; f < N; f++) v[k][f] = 0;
    end
    prev = '{0, 0, 0, 0};

    //        r  e  d  i  u  dn c
    paso(1, 0, 0, 0, 0, 0, 0, CERO);
    paso(1, 0, 0, 0, 0, 0, 0, CERO);
    paso(0, 1, 0, 0, 0, 0, 0, CERO);
    paso(0, 1, 1, 0, 0, 0, 0, CERO);          // cursor -> 1
    paso(0, 1, 0, 0, 0, 0, 0, CERO);
    for (int t = 0; t < 10; t++) paso(0, 1, 1, 0, 0, 0, 0, CERO);  // one step only
    paso(0, 1, 0, 0, 0, 0, 0, CERO);
    paso(0, 1, 1, 0, 0, 0, 0, CERO);          // at last field: wrap vs hold
    paso(0, 1, 0, 0, 0, 0, 0, CERO);
    paso(1, 1, 0, 0, 0, 0, 0, CERO);
    paso(0, 1, 0, 1, 0, 0, 0, CERO);          // left at 0: wrap to 2 vs hold at 0
    paso(0, 1, 0, 0, 0, 0, 0, CERO);
    paso(1, 1, 0, 0, 0, 0, 0, CERO);

    paso(0, 1, 0, 0, 1, 0, 1, {6'd12, 6'd45, 6'd30});  // clamp field0, press discarded
    paso(0, 1, 0, 0, 0, 0, 0, CERO);
    paso(0, 1, 0, 0, 1, 0, 0, CERO);          // field0 23 -> 0
    paso(0, 1, 0, 0, 0, 0, 0, CERO);
    paso(0, 1, 0, 0, 0, 0, 1, {6'd12, 6'd0, 6'd5});
    paso(0, 1, 1, 0, 0, 0, 0, CERO);
    paso(0, 1, 0, 0, 0, 1, 0, CERO);          // field1 0 -> 59
    paso(0, 1, 0, 0, 0, 0, 0, CERO);
    paso(0, 1, 0, 1, 0, 0, 0, CERO);
    paso(0, 1, 0, 0, 0, 0, 0, CERO);
    paso(0, 1, 1, 0, 1, 0, 0, CERO);          // edit field0 and move together
    paso(0, 1, 0, 0, 0, 0, 0, CERO);
    paso(0, 1, 1, 1, 0, 0, 0, CERO);          // no move
    paso(0, 1, 0, 0, 0, 0, 0, CERO);
    paso(0, 1, 0, 0, 1, 1, 0, CERO);          // no change
    paso(0, 1, 0, 0, 0, 0, 0, CERO);
    paso(0, 0, 1, 0, 1, 0, 0, CERO);          // disabled: ignored
    paso(0, 0, 0, 0, 0, 0, 0, CERO);
    paso(0, 0, 0, 1, 0, 1, 0, CERO);
    paso(0, 1, 0, 1, 0, 1, 0, CERO);          // held across enable: no press
    paso(0, 1, 0, 0, 0, 0, 0, CERO);
    paso(0, 1, 1, 0, 1, 0, 0, CERO);
    paso(1, 1, 1, 0, 1, 0, 1, {6'd9, 6'd9, 6'd9});     // reset overrides all
    paso(0, 1, 1, 0, 1, 0, 0, CERO);          // held through reset: press after release of rst

    for (int t = 0; t < 800; t++) begin
      paso($urandom_range(0, 99) == 0, $urandom_range(0, 9) != 0,
           $urandom_range(0, 2) == 0, $urandom_range(0, 2) == 0,
           $urandom_range(0, 2) == 0, $urandom_range(0, 2) == 0,
           $urandom_range(0, 19) == 0, (N*W)'($urandom));
    end
    paso(0, 1, 0, 0, 0, 0, 0, CERO);

    for (int t = 0; t < 20 && cola.size() > 0; t++) @(posedge clk);
    #2;
    if (cola.size() != 0) begin
      n_err++;
      $display("FAIL drain: got %0d pending expected 0", cola.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
